// File: rtl/anemo_pio_pkg.sv
// Shared constants for the anemometer input PIO: register map, edge-select
// encodings and CTRL bit positions.
package anemo_pio_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_CTRL = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_CNT  = 3'd4;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  localparam int unsigned CTRL_CNT_EN  = 0;
  localparam int unsigned CTRL_CNT_CLR = 1;

endpackage

// File: rtl/anemo_sync_edge.sv
// Multi-stage input synchroniser with per-bit edge detection, gated off
// until the pipeline has filled after reset.
module anemo_sync_edge
  import anemo_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_edge
);

  // Warm-up ends once sync and prev both hold post-reset samples.
  localparam logic [2:0] WARM_DONE = 3'(STAGES + 1);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]             r_prev;
  logic [2:0]                   r_warm;
  logic [WIDTH-1:0]             w_rise;
  logic [WIDTH-1:0]             w_fall;
  logic [WIDTH-1:0]             w_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
      r_warm <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
      if (r_warm != WARM_DONE) r_warm <= r_warm + 3'd1;
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign w_rise = o_sync & ~r_prev;
  assign w_fall = ~o_sync & r_prev;

  always_comb begin
    w_sel = w_rise;
    if (EDGE_TYPE == EDGE_FALL)     w_sel = w_fall;
    else if (EDGE_TYPE == EDGE_ANY) w_sel = w_rise | w_fall;
  end

  assign o_edge = (r_warm == WARM_DONE) ? w_sel : '0;

endmodule

// File: rtl/anemo_pio_in_irq.sv
// Avalon-MM input PIO: synchronised input bus, W1C edge capture with
// maskable level irq, and a saturating pulse counter on one bit.
module anemo_pio_in_irq
  import anemo_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned CNT_BIT     = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] w_sync;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_w1c;
  logic [31:0]           w_rdata;
  logic                  w_wr;
  logic                  w_cnt_clr;
  logic                  w_unused;

  logic                  r_cnt_en;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_edge_cap;
  logic [31:0]           r_pulse_cnt;

  anemo_sync_edge #(
    .WIDTH    (DATA_WIDTH),
    .STAGES   (SYNC_STAGES),
    .EDGE_TYPE(EDGE_TYPE)
  ) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .i_async(in_port),
    .o_sync (w_sync),
    .o_edge (w_edge)
  );

  assign w_wr      = chipselect & ~write_n;
  assign w_w1c     = (w_wr && address == ADDR_EDGE) ? writedata[DATA_WIDTH-1:0] : '0;
  assign w_cnt_clr = w_wr && address == ADDR_CTRL && writedata[CTRL_CNT_CLR];
  assign w_unused  = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_en <= 1'b0;
      r_mask   <= '0;
    end else if (w_wr) begin
      if (address == ADDR_CTRL) r_cnt_en <= writedata[CTRL_CNT_EN];
      if (address == ADDR_MASK) r_mask   <= writedata[DATA_WIDTH-1:0];
    end
  end

  // New edges are OR'd in after the clear so a coincident edge survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_edge_cap <= '0;
    else          r_edge_cap <= (r_edge_cap & ~w_w1c) | w_edge;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_pulse_cnt <= '0;
    else if (w_cnt_clr)
      r_pulse_cnt <= '0;
    else if (r_cnt_en && w_edge[CNT_BIT] && r_pulse_cnt != '1)
      r_pulse_cnt <= r_pulse_cnt + 32'd1;
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA: w_rdata = 32'(w_sync);
      ADDR_CTRL: w_rdata = {31'b0, r_cnt_en};
      ADDR_MASK: w_rdata = 32'(r_mask);
      ADDR_EDGE: w_rdata = 32'(r_edge_cap);
      ADDR_CNT:  w_rdata = r_pulse_cnt;
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rdata;
  end

  assign irq = |(r_edge_cap & r_mask);

endmodule

// File: tb/tb_anemo_pio_in_irq.sv
// Directed bench: a rising-edge instance and an any-edge instance share the
// bus and input pins; each scenario task checks its own expected values.
module tb_anemo_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = 8'hFF;
  logic [31:0] rd0, rd2;
  logic        irq0, irq2;
  logic [31:0] d0, d2;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  anemo_pio_in_irq #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .CNT_BIT(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));

  anemo_pio_in_irq #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .CNT_BIT(0)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port), .irq(irq2));

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] o0, output logic [31:0] o2);
    @(negedge clk);
    address = a;
    @(negedge clk);
    o0 = rd0;
    o2 = rd2;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      in_port[0] = 1'b1; idle(4);
      in_port[0] = 1'b0; idle(4);
    end
  endtask

  task automatic test_reset;
    idle(3);
    reset_n = 1'b1;
    idle(10);
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq0); end
    checks++; if (irq2 !== 1'b0) begin failures++; $display("FAIL reset_irq_any got=%b exp=0", irq2); end
    bus_read(3'd3, d0, d2);
    checks++; if (d0 !== 32'h0) begin failures++; $display("FAIL reset_edge got=%h exp=%h", d0, 32'h0); end
    checks++; if (d2 !== 32'h0) begin failures++; $display("FAIL reset_edge_any got=%h exp=%h", d2, 32'h0); end
    bus_read(3'd0, d0, d2);
    checks++; if (d0 !== 32'h0000_00FF) begin failures++; $display("FAIL reset_data got=%h exp=%h", d0, 32'hFF); end
  endtask

  task automatic test_edge_irq;
    in_port = 8'h00;
    idle(5);
    bus_write(3'd2, 32'h01);
    bus_write(3'd3, 32'hFF);
    bus_read(3'd3, d0, d2);
    checks++; if (d0 !== 32'h0) begin failures++; $display("FAIL fall_ignored got=%h exp=%h", d0, 32'h0); end
    in_port = 8'h01;
    idle(2);
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq0); end
    idle(1);
    checks++; if (irq0 !== 1'b1) begin failures++; $display("FAIL irq_n3 got=%b exp=1", irq0); end
    bus_read(3'd3, d0, d2);
    checks++; if (d0 !== 32'h01) begin failures++; $display("FAIL edge_bit0 got=%h exp=%h", d0, 32'h01); end
    bus_write(3'd3, 32'h01);
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", irq0); end
  endtask

  task automatic test_w1c_collision;
    in_port = 8'h05;
    idle(2);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd3; writedata = 32'h04;
    idle(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    bus_read(3'd3, d0, d2);
    checks++; if (d0 !== 32'h04) begin failures++; $display("FAIL w1c_set_wins got=%h exp=%h", d0, 32'h04); end
    bus_write(3'd3, 32'h04);
    bus_read(3'd3, d0, d2);
    checks++; if (d0 !== 32'h0) begin failures++; $display("FAIL w1c_clear got=%h exp=%h", d0, 32'h0); end
  endtask

  task automatic test_pulse_count;
    bus_write(3'd1, 32'h1);
    in_port = 8'h04;
    idle(5);
    pulse(100);
    idle(5);
    bus_read(3'd4, d0, d2);
    checks++; if (d0 !== 32'd100) begin failures++; $display("FAIL cnt_100 got=%0d exp=100", d0); end
    checks++; if (d2 !== 32'd201) begin failures++; $display("FAIL cnt_any_201 got=%0d exp=201", d2); end
    bus_write(3'd1, 32'h3);
    bus_read(3'd4, d0, d2);
    checks++; if (d0 !== 32'd0) begin failures++; $display("FAIL cnt_clr got=%0d exp=0", d0); end
    bus_read(3'd1, d0, d2);
    checks++; if (d0 !== 32'h1) begin failures++; $display("FAIL ctrl_after_clr got=%h exp=%h", d0, 32'h1); end
  endtask

  task automatic test_cnt_collisions;
    in_port[0] = 1'b1;
    idle(2);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 32'h0;
    idle(1);
    chipselect = 1'b0; write_n = 1'b1;
    idle(3);
    bus_read(3'd4, d0, d2);
    checks++; if (d0 !== 32'd1) begin failures++; $display("FAIL en_off_edge got=%0d exp=1", d0); end
    in_port[0] = 1'b0; idle(5);
    in_port[0] = 1'b1; idle(5);
    in_port[0] = 1'b0; idle(5);
    bus_read(3'd4, d0, d2);
    checks++; if (d0 !== 32'd1) begin failures++; $display("FAIL cnt_disabled got=%0d exp=1", d0); end
    bus_write(3'd1, 32'h1);
    in_port[0] = 1'b1;
    idle(2);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 32'h3;
    idle(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    idle(3);
    bus_read(3'd4, d0, d2);
    checks++; if (d0 !== 32'd0) begin failures++; $display("FAIL clr_wins got=%0d exp=0", d0); end
    in_port[0] = 1'b0;
    idle(5);
  endtask

  task automatic test_saturate;
    @(negedge clk);
    force dut.r_pulse_cnt = 32'hFFFF_FFFD;
    @(negedge clk);
    release dut.r_pulse_cnt;
    bus_read(3'd4, d0, d2);
    checks++; if (d0 !== 32'hFFFF_FFFD) begin failures++; $display("FAIL cnt_preload got=%h exp=%h", d0, 32'hFFFF_FFFD); end
    pulse(3);
    idle(3);
    bus_read(3'd4, d0, d2);
    checks++; if (d0 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cnt_saturate got=%h exp=%h", d0, 32'hFFFF_FFFF); end
  endtask

  task automatic test_edge_any;
    bus_write(3'd3, 32'hFF);
    in_port = 8'h24;
    idle(5);
    bus_read(3'd3, d0, d2);
    checks++; if (d0 !== 32'h20) begin failures++; $display("FAIL rise_bit5 got=%h exp=%h", d0, 32'h20); end
    checks++; if (d2 !== 32'h20) begin failures++; $display("FAIL any_rise_bit5 got=%h exp=%h", d2, 32'h20); end
    bus_write(3'd3, 32'h20);
    in_port = 8'h04;
    idle(5);
    bus_read(3'd3, d0, d2);
    checks++; if (d0 !== 32'h0) begin failures++; $display("FAIL rise_no_fall got=%h exp=%h", d0, 32'h0); end
    checks++; if (d2 !== 32'h20) begin failures++; $display("FAIL any_fall_bit5 got=%h exp=%h", d2, 32'h20); end
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, d0, d2);
    checks++; if (d0 !== 32'h0) begin failures++; $display("FAIL addr6 got=%h exp=%h", d0, 32'h0); end
    checks++; if (d2 !== 32'h0) begin failures++; $display("FAIL addr6_any got=%h exp=%h", d2, 32'h0); end
  endtask

  task automatic test_reset_mid;
    bus_write(3'd2, 32'h20);
    checks++; if (irq2 !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got=%b exp=1", irq2); end
    bus_read(3'd4, d0, d2);
    checks++; if (d0 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL pre_reset_cnt got=%h exp=%h", d0, 32'hFFFF_FFFF); end
    in_port = 8'hFF;
    reset_n = 1'b0;
    #1;
    checks++; if (irq2 !== 1'b0) begin failures++; $display("FAIL mid_reset_irq got=%b exp=0", irq2); end
    checks++; if (rd0 !== 32'h0) begin failures++; $display("FAIL mid_reset_readdata got=%h exp=%h", rd0, 32'h0); end
    idle(2);
    reset_n = 1'b1;
    idle(10);
    checks++; if (irq2 !== 1'b0) begin failures++; $display("FAIL post_reset_irq got=%b exp=0", irq2); end
    bus_read(3'd3, d0, d2);
    checks++; if (d0 !== 32'h0) begin failures++; $display("FAIL post_reset_edge got=%h exp=%h", d0, 32'h0); end
    checks++; if (d2 !== 32'h0) begin failures++; $display("FAIL post_reset_edge_any got=%h exp=%h", d2, 32'h0); end
    bus_read(3'd4, d0, d2);
    checks++; if (d0 !== 32'h0) begin failures++; $display("FAIL post_reset_cnt got=%h exp=%h", d0, 32'h0); end
    bus_read(3'd2, d0, d2);
    checks++; if (d2 !== 32'h0) begin failures++; $display("FAIL post_reset_mask got=%h exp=%h", d2, 32'h0); end
    bus_read(3'd1, d0, d2);
    checks++; if (d0 !== 32'h0) begin failures++; $display("FAIL post_reset_ctrl got=%h exp=%h", d0, 32'h0); end
    bus_read(3'd0, d0, d2);
    checks++; if (d0 !== 32'hFF) begin failures++; $display("FAIL post_reset_data got=%h exp=%h", d0, 32'hFF); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_edge_irq();
    test_w1c_collision();
    test_pulse_count();
    test_cnt_collisions();
    test_saturate();
    test_edge_any();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
